// File: rtl/ysyx_24090012_axi_sram_slave.sv
// AXI4 slave with a word-organised on-chip SRAM.
// One transaction at a time; FIXED/INCR bursts, strobes, read latency, SLVERR.
module ysyx_24090012_axi_sram_slave #(
  parameter logic [31:0] BASE   = 32'h8000_0000,
  parameter int          DEPTH  = 1024,
  parameter int          RD_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        axi_awvalid,
  output logic        axi_awready,
  input  logic [31:0] axi_awaddr,
  input  logic [3:0]  axi_awid,
  input  logic [7:0]  axi_awlen,
  input  logic [2:0]  axi_awsize,
  input  logic [1:0]  axi_awburst,
  input  logic        axi_wvalid,
  output logic        axi_wready,
  input  logic [31:0] axi_wdata,
  input  logic [3:0]  axi_wstrb,
  input  logic        axi_wlast,
  output logic        axi_bvalid,
  input  logic        axi_bready,
  output logic [1:0]  axi_bresp,
  output logic [3:0]  axi_bid,
  input  logic        axi_arvalid,
  output logic        axi_arready,
  input  logic [31:0] axi_araddr,
  input  logic [3:0]  axi_arid,
  input  logic [7:0]  axi_arlen,
  input  logic [2:0]  axi_arsize,
  input  logic [1:0]  axi_arburst,
  output logic        axi_rvalid,
  input  logic        axi_rready,
  output logic [31:0] axi_rdata,
  output logic [1:0]  axi_rresp,
  output logic        axi_rlast,
  output logic [3:0]  axi_rid
);

  localparam int          AW     = $clog2(DEPTH);
  localparam logic [31:0] LIMIT  = 32'(DEPTH * 4);
  localparam logic [3:0]  LAT_M1 =
    (RD_LAT == 0) ? 4'd0 : 4'(RD_LAT - 1);

  typedef enum logic [2:0] {
    IDLE, W_DATA, W_RESP, R_WAIT, R_DATA
  } state_t;

  state_t      state;
  logic [31:0] addr;
  logic [3:0]  id;
  logic [7:0]  len;
  logic [7:0]  beat;
  logic [2:0]  size;
  logic [1:0]  burst;
  logic        err;
  logic [3:0]  cnt;

  logic [31:0] mem [DEPTH];

  logic [31:0] off;
  logic [31:0] step;
  logic [AW-1:0] idx;
  logic        oor;
  logic        last_beat;
  logic        aw_hs;
  logic        ar_hs;
  logic        w_hs;
  logic        bad_aw;
  logic        bad_ar;
  logic        werr;

  // Address decode, burst step and handshake qualifiers
  always_comb begin
    off       = addr - BASE;
    oor       = (off >= LIMIT);
    idx       = off[AW+1:2];
    last_beat = (beat == len);
    step      = (burst == 2'b01) ? (32'd1 << size) : 32'd0;
    aw_hs     = axi_awvalid && axi_awready;
    ar_hs     = axi_arvalid && axi_arready;
    w_hs      = axi_wvalid && axi_wready;
    bad_aw    = (axi_awsize > 3'd2) || axi_awburst[1];
    bad_ar    = (axi_arsize > 3'd2) || axi_arburst[1];
    werr      = err || oor || (axi_wlast != last_beat);
  end

  assign axi_awready = (state == IDLE);
  assign axi_arready = (state == IDLE) && !axi_awvalid;

  // Read beat payload; addr is frozen while stalled so it stays stable
  always_comb begin
    axi_rdata = 32'd0;
    axi_rresp = 2'b00;
    axi_rlast = 1'b0;
    if (axi_rvalid) begin
      axi_rdata = oor ? 32'd0 : mem[idx];
      axi_rresp = (err || oor) ? 2'b10 : 2'b00;
      axi_rlast = last_beat;
    end
  end

  // Transaction FSM with registered handshake and response outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      axi_wready <= 1'b0;
      axi_bvalid <= 1'b0;
      axi_bresp  <= 2'b00;
      axi_bid    <= 4'd0;
      axi_rvalid <= 1'b0;
      axi_rid    <= 4'd0;
      addr       <= 32'd0;
      id         <= 4'd0;
      len        <= 8'd0;
      beat       <= 8'd0;
      size       <= 3'd0;
      burst      <= 2'b00;
      err        <= 1'b0;
      cnt        <= 4'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (aw_hs) begin
            addr       <= axi_awaddr;
            id         <= axi_awid;
            len        <= axi_awlen;
            size       <= axi_awsize;
            burst      <= axi_awburst;
            beat       <= 8'd0;
            err        <= bad_aw;
            axi_wready <= 1'b1;
            state      <= W_DATA;
          end else if (ar_hs) begin
            addr    <= axi_araddr;
            id      <= axi_arid;
            len     <= axi_arlen;
            size    <= axi_arsize;
            burst   <= axi_arburst;
            beat    <= 8'd0;
            err     <= bad_ar;
            cnt     <= LAT_M1;
            axi_rid <= axi_arid;
            if (RD_LAT == 0) begin
              axi_rvalid <= 1'b1;
              state      <= R_DATA;
            end else begin
              state <= R_WAIT;
            end
          end
        end
        W_DATA: begin
          if (w_hs) begin
            addr <= addr + step;
            beat <= beat + 8'd1;
            err  <= werr;
            if (last_beat) begin
              axi_wready <= 1'b0;
              axi_bvalid <= 1'b1;
              axi_bid    <= id;
              axi_bresp  <= werr ? 2'b10 : 2'b00;
              state      <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (axi_bready) begin
            axi_bvalid <= 1'b0;
            axi_bresp  <= 2'b00;
            axi_bid    <= 4'd0;
            state      <= IDLE;
          end
        end
        R_WAIT: begin
          if (cnt == 4'd0) begin
            axi_rvalid <= 1'b1;
            state      <= R_DATA;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        R_DATA: begin
          if (axi_rready) begin
            addr <= addr + step;
            beat <= beat + 8'd1;
            err  <= err || oor;
            if (last_beat) begin
              axi_rvalid <= 1'b0;
              axi_rid    <= 4'd0;
              state      <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Strobed SRAM write; out-of-range beats are dropped
  always_ff @(posedge clk) begin
    if (!rst && w_hs && !oor) begin
      for (int b = 0; b < 4; b++) begin
        if (axi_wstrb[b]) mem[idx][8*b +: 8] <= axi_wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ysyx_24090012_axi_sram_slave.sv
// Bench for the AXI SRAM slave.
// Reference memory model plus read-beat scoreboard queue.
module tb_ysyx_24090012_axi_sram_slave;

  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        awvalid = 0, awready;
  logic [31:0] awaddr = 0;
  logic [3:0]  awid = 0;
  logic [7:0]  awlen = 0;
  logic [2:0]  awsize = 0;
  logic [1:0]  awburst = 0;
  logic        wvalid = 0, wready;
  logic [31:0] wdata = 0;
  logic [3:0]  wstrb = 0;
  logic        wlast = 0;
  logic        bvalid, bready = 0;
  logic [1:0]  bresp;
  logic [3:0]  bid;
  logic        arvalid = 0, arready;
  logic [31:0] araddr = 0;
  logic [3:0]  arid = 0;
  logic [7:0]  arlen = 0;
  logic [2:0]  arsize = 0;
  logic [1:0]  arburst = 0;
  logic        rvalid, rready = 0;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic [3:0]  rid;

  ysyx_24090012_axi_sram_slave dut (
    .clk(clk), .rst(rst),
    .axi_awvalid(awvalid), .axi_awready(awready),
    .axi_awaddr(awaddr), .axi_awid(awid), .axi_awlen(awlen),
    .axi_awsize(awsize), .axi_awburst(awburst),
    .axi_wvalid(wvalid), .axi_wready(wready),
    .axi_wdata(wdata), .axi_wstrb(wstrb), .axi_wlast(wlast),
    .axi_bvalid(bvalid), .axi_bready(bready),
    .axi_bresp(bresp), .axi_bid(bid),
    .axi_arvalid(arvalid), .axi_arready(arready),
    .axi_araddr(araddr), .axi_arid(arid), .axi_arlen(arlen),
    .axi_arsize(arsize), .axi_arburst(arburst),
    .axi_rvalid(rvalid), .axi_rready(rready),
    .axi_rdata(rdata), .axi_rresp(rresp),
    .axi_rlast(rlast), .axi_rid(rid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [3:0]  id;
  } rexp_t;

  rexp_t       sb[$];
  logic [31:0] mdl [DEPTH];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic axi_write(
    input logic [31:0] a, input logic [3:0] i, input logic [7:0] l,
    input logic [2:0] sz, input logic [1:0] bu, input logic [31:0] d0,
    input logic [3:0] st, input int bad_beat,
    output logic [1:0] resp, output logic [3:0] rbid);
    int n;
    logic [31:0] ca, off;
    awvalid = 1; awaddr = a; awid = i; awlen = l;
    awsize = sz; awburst = bu;
    #1;
    n = 0;
    while (!awready && n < 100) begin tick(); #1; n++; end
    if (n >= 100) begin
      checks++; failures++;
      $display("FAIL aw_timeout awready=%0b required=1", awready);
    end
    tick();
    awvalid = 0;
    for (int b = 0; b <= int'(l); b++) begin
      wvalid = 1; wdata = d0 + 32'(b); wstrb = st;
      wlast = (b == int'(l)) ^ (b == bad_beat);
      #1;
      n = 0;
      while (!wready && n < 100) begin tick(); #1; n++; end
      if (n >= 100) begin
        checks++; failures++;
        $display("FAIL w_timeout beat=%0d wready=%0b required=1", b, wready);
      end
      tick();
      ca = a + ((bu == 2'b01) ? (32'(b) << sz) : 32'd0);
      off = ca - BASE;
      if (off < 32'(DEPTH * 4)) begin
        for (int k = 0; k < 4; k++)
          if (st[k]) mdl[off[11:2]][8*k +: 8] = wdata[8*k +: 8];
      end
    end
    wvalid = 0; wlast = 0; bready = 1;
    #1;
    n = 0;
    while (!bvalid && n < 100) begin tick(); #1; n++; end
    if (n >= 100) begin
      checks++; failures++;
      $display("FAIL b_timeout bvalid=%0b required=1", bvalid);
    end
    resp = bresp; rbid = bid;
    tick();
    bready = 0;
  endtask

  task automatic ar_issue(
    input logic [31:0] a, input logic [3:0] i, input logic [7:0] l,
    input logic [2:0] sz, input logic [1:0] bu, output int t);
    int n;
    logic e;
    logic [31:0] ca, off;
    rexp_t x;
    e = (sz > 3'd2) || bu[1];
    for (int b = 0; b <= int'(l); b++) begin
      ca = a + ((bu == 2'b01) ? (32'(b) << sz) : 32'd0);
      off = ca - BASE;
      e = e || (off >= 32'(DEPTH * 4));
      x.data = (off >= 32'(DEPTH * 4)) ? 32'd0 : mdl[off[11:2]];
      x.resp = e ? 2'b10 : 2'b00;
      x.last = (b == int'(l));
      x.id   = i;
      sb.push_back(x);
    end
    arvalid = 1; araddr = a; arid = i; arlen = l;
    arsize = sz; arburst = bu;
    #1;
    n = 0;
    while (!arready && n < 100) begin tick(); #1; n++; end
    if (n >= 100) begin
      checks++; failures++;
      $display("FAIL ar_timeout arready=%0b required=1", arready);
    end
    t = cyc;
    tick();
    arvalid = 0;
  endtask

  task automatic read_data(
    input int nb, input logic [15:0] pat, input int plen,
    output int first);
    int got, k, n;
    rexp_t e;
    got = 0; k = 0; n = 0; first = -1;
    while (got < nb && n < 200) begin
      if (rvalid) begin
        if (first < 0) first = cyc;
        rready = (k < plen) ? pat[k] : 1'b1;
        k++;
      end else begin
        rready = 0;
      end
      #1;
      if (rvalid && sb.size() > 0) begin
        e = sb[0];
        checks++;
        if (rdata !== e.data || rresp !== e.resp ||
            rlast !== e.last || rid !== e.id) begin
          failures++;
          $display("FAIL r_beat%0d got d=%h r=%b l=%b id=%h required d=%h r=%b l=%b id=%h",
                   got, rdata, rresp, rlast, rid,
                   e.data, e.resp, e.last, e.id);
        end
        if (rready) begin
          void'(sb.pop_front());
          got++;
        end
      end
      tick();
      n++;
    end
    rready = 0;
    if (got < nb) begin
      checks++; failures++;
      $display("FAIL r_timeout beats=%0d required=%0d", got, nb);
    end
    #1;
    checks++;
    if (rvalid !== 1'b0) begin
      failures++;
      $display("FAIL r_end rvalid=%b required=0", rvalid);
    end
    tick();
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (2) tick();
    rst = 0;
    #1;
    checks++;
    if (bvalid !== 1'b0) begin failures++; $display("FAIL rst_bvalid got=%b required=0", bvalid); end
    checks++;
    if (rvalid !== 1'b0) begin failures++; $display("FAIL rst_rvalid got=%b required=0", rvalid); end
    checks++;
    if (awready !== 1'b1) begin failures++; $display("FAIL rst_awready got=%b required=1", awready); end
    checks++;
    if (arready !== 1'b1) begin failures++; $display("FAIL rst_arready got=%b required=1", arready); end
    checks++;
    if (wready !== 1'b0 || rlast !== 1'b0) begin
      failures++; $display("FAIL rst_misc wready=%b rlast=%b required=0,0", wready, rlast);
    end
    tick();
  endtask

  task automatic test_single();
    logic [1:0] r;
    logic [3:0] b;
    int t, f;
    axi_write(BASE + 32'h10, 4'h2, 8'd0, 3'd2, 2'b01, 32'h0, 4'hF, -1, r, b);
    axi_write(BASE + 32'h10, 4'hA, 8'd0, 3'd2, 2'b01, 32'hDEADBEEF, 4'b0101, -1, r, b);
    checks++;
    if (r !== 2'b00) begin failures++; $display("FAIL single_bresp got=%b required=00", r); end
    checks++;
    if (b !== 4'hA) begin failures++; $display("FAIL single_bid got=%h required=a", b); end
    ar_issue(BASE + 32'h10, 4'h4, 8'd0, 3'd2, 2'b01, t);
    read_data(1, 16'h0, 0, f);
  endtask

  task automatic test_incr_burst();
    logic [1:0] r;
    logic [3:0] b;
    int t, f;
    axi_write(BASE, 4'h1, 8'd3, 3'd2, 2'b01, 32'h1111_0000, 4'hF, -1, r, b);
    checks++;
    if (r !== 2'b00 || b !== 4'h1) begin
      failures++; $display("FAIL wburst_resp got=%b/%h required=00/1", r, b);
    end
    ar_issue(BASE, 4'h5, 8'd3, 3'd2, 2'b01, t);
    read_data(4, 16'b10_1101, 6, f);
    checks++;
    if (f != t + 2) begin
      failures++; $display("FAIL rd_latency first=%0d required=%0d", f, t + 2);
    end
  endtask

  task automatic test_fixed_burst();
    logic [1:0] r;
    logic [3:0] b;
    int t, f;
    axi_write(BASE + 32'h40, 4'h7, 8'd2, 3'd2, 2'b00, 32'h5A5A_0000, 4'hF, -1, r, b);
    checks++;
    if (r !== 2'b00) begin failures++; $display("FAIL fixed_bresp got=%b required=00", r); end
    ar_issue(BASE + 32'h40, 4'h8, 8'd2, 3'd2, 2'b00, t);
    read_data(3, 16'h0, 0, f);
  endtask

  task automatic test_aw_ar_collision();
    int n, f;
    logic done, wbeat;
    rexp_t x;
    awvalid = 1; awaddr = BASE + 32'h20; awid = 4'h3;
    awlen = 0; awsize = 2; awburst = 2'b01;
    arvalid = 1; araddr = BASE + 32'h20; arid = 4'h9;
    arlen = 0; arsize = 2; arburst = 2'b01;
    #1;
    checks++;
    if (awready !== 1'b1 || arready !== 1'b0) begin
      failures++; $display("FAIL coll_idle awready=%b arready=%b required=1,0", awready, arready);
    end
    tick();
    awvalid = 0;
    wvalid = 1; wdata = 32'hCAFEF00D; wstrb = 4'hF; wlast = 1; bready = 1;
    mdl[8] = 32'hCAFEF00D;
    done = 0; n = 0;
    while (!done && n < 20) begin
      #1;
      checks++;
      if (arready !== 1'b0) begin
        failures++; $display("FAIL coll_blocked cyc=%0d arready=%b required=0", cyc, arready);
      end
      wbeat = wvalid && wready;
      if (bvalid) begin
        done = 1;
        checks++;
        if (bid !== 4'h3 || bresp !== 2'b00) begin
          failures++; $display("FAIL coll_b bid=%h bresp=%b required=3,00", bid, bresp);
        end
      end
      tick();
      n++;
      if (wbeat) begin wvalid = 0; wlast = 0; end
    end
    bready = 0;
    if (!done) begin
      checks++; failures++; $display("FAIL coll_b_timeout bvalid=%b required=1", bvalid);
    end
    #1;
    checks++;
    if (arready !== 1'b1) begin
      failures++; $display("FAIL coll_ar_after arready=%b required=1", arready);
    end
    x.data = mdl[8]; x.resp = 2'b00; x.last = 1'b1; x.id = 4'h9;
    sb.push_back(x);
    tick();
    arvalid = 0;
    read_data(1, 16'h0, 0, f);
  endtask

  task automatic test_out_of_range();
    logic [1:0] r;
    logic [3:0] b;
    int t, f;
    axi_write(32'h0000_0000, 4'hC, 8'd1, 3'd2, 2'b01, 32'hBAD0_0000, 4'hF, -1, r, b);
    checks++;
    if (r !== 2'b10) begin failures++; $display("FAIL oor_bresp got=%b required=10", r); end
    ar_issue(BASE, 4'h2, 8'd1, 3'd2, 2'b01, t);
    read_data(2, 16'h0, 0, f);
    ar_issue(BASE + 32'(DEPTH * 4), 4'h3, 8'd0, 3'd2, 2'b01, t);
    read_data(1, 16'h0, 0, f);
  endtask

  task automatic test_wlast_err();
    logic [1:0] r;
    logic [3:0] b;
    int t, f;
    axi_write(BASE + 32'h100, 4'hE, 8'd1, 3'd2, 2'b01, 32'h7700_0000, 4'hF, 0, r, b);
    checks++;
    if (r !== 2'b10 || b !== 4'hE) begin
      failures++; $display("FAIL wlast_bresp got=%b/%h required=10/e", r, b);
    end
    ar_issue(BASE + 32'h100, 4'h1, 8'd1, 3'd2, 2'b01, t);
    read_data(2, 16'h0, 0, f);
  endtask

  task automatic test_reset_mid_burst();
    int t, f, got, n;
    rexp_t e;
    ar_issue(BASE, 4'h6, 8'd7, 3'd2, 2'b01, t);
    rready = 1; got = 0; n = 0;
    while (got < 2 && n < 50) begin
      #1;
      if (rvalid && sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (rdata !== e.data || rid !== e.id) begin
          failures++; $display("FAIL abort_beat%0d got d=%h id=%h required d=%h id=%h",
                               got, rdata, rid, e.data, e.id);
        end
        got++;
      end
      tick();
      n++;
    end
    rst = 1;
    tick();
    checks++;
    if (rvalid !== 1'b0 || rlast !== 1'b0 || rid !== 4'h0) begin
      failures++; $display("FAIL abort_rst rvalid=%b rlast=%b rid=%h required=0,0,0",
                           rvalid, rlast, rid);
    end
    rst = 0; rready = 0;
    sb.delete();
    tick();
    ar_issue(BASE + 32'h10, 4'hB, 8'd0, 3'd2, 2'b01, t);
    read_data(1, 16'h0, 0, f);
  endtask

  initial begin
    test_reset();
    test_single();
    test_incr_burst();
    test_fixed_burst();
    test_aw_ar_collision();
    test_out_of_range();
    test_wlast_err();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
